// File: rtl/combo_entry_ctrl.sv
// combo_entry_ctrl: keypad digit entry, password store/compare and failed-attempt lockout
module combo_entry_ctrl #(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000,
    localparam int BW = DIGITS * DIGIT_W,
    localparam int CW = $clog2(DIGITS + 1),
    localparam int FW = $clog2(MAX_FAILS + 1),
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               setPW,
    input  logic               attPW,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               enter_pulse,
    input  logic               clear_pulse,
    output logic               match,
    output logic               key_inhibit,
    output logic [BW-1:0]      entry_buf,
    output logic [CW-1:0]      entry_cnt,
    output logic [FW-1:0]      fail_cnt,
    output logic               pw_set
);
    typedef enum logic [1:0] {IDLE, COLLECT, LOCKOUT} state_e;
    state_e state_q, state_d;
    logic [BW-1:0] buf_q, buf_d, pw_q, pw_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic match_q, match_d, pw_set_q, pw_set_d;
    logic armed, in_col, full, enter_ev, clear_ev, digit_ev, lock_go, tmr_done;
    assign armed    = setPW | attPW;
    assign in_col   = (state_q == COLLECT) && armed;
    assign full     = cnt_q == CW'(DIGITS);
    // enter beats clear beats digit; the loser in a shared cycle is dropped
    assign enter_ev = in_col && enter_pulse;
    assign clear_ev = in_col && clear_pulse && !enter_pulse;
    assign digit_ev = in_col && digit_valid && !enter_pulse && !clear_pulse && !full;
    assign lock_go  = enter_ev && !setPW && !match_q && (fail_q + FW'(1) == FW'(MAX_FAILS));
    assign tmr_done = tmr_q == TW'(LOCKOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = armed ? COLLECT : IDLE;
            COLLECT: state_d = lock_go ? LOCKOUT : (armed ? COLLECT : IDLE);
            LOCKOUT: state_d = tmr_done ? IDLE : LOCKOUT;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        key_inhibit = state_q == LOCKOUT;
    end
    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        pw_d     = pw_q;
        pw_set_d = pw_set_q;
        fail_d   = fail_q;
        tmr_d    = (state_q == LOCKOUT && !tmr_done) ? tmr_q + TW'(1) : '0;
        if ((state_q == IDLE && armed) || enter_ev || clear_ev) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (digit_ev) begin
            buf_d = (buf_q << DIGIT_W) | BW'(digit_in);
            cnt_d = cnt_q + CW'(1);
        end
        if (enter_ev && setPW) begin
            pw_d     = buf_q;
            pw_set_d = 1'b1;
            fail_d   = '0;
        end else if (enter_ev) begin
            fail_d = match_q ? '0 : fail_q + FW'(1);
        end
        if (state_q == LOCKOUT && tmr_done) fail_d = '0;
        // only meaningful while the entry stays in COLLECT across this edge
        match_d = (state_q == COLLECT) && (state_d == COLLECT) && full && pw_set_q && (buf_q == pw_q);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q    <= '0;
            cnt_q    <= '0;
            pw_q     <= '0;
            pw_set_q <= 1'b0;
            fail_q   <= '0;
            tmr_q    <= '0;
            match_q  <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            pw_q     <= pw_d;
            pw_set_q <= pw_set_d;
            fail_q   <= fail_d;
            tmr_q    <= tmr_d;
            match_q  <= match_d;
        end
    end
    assign match     = match_q;
    assign entry_buf = buf_q;
    assign entry_cnt = cnt_q;
    assign fail_cnt  = fail_q;
    assign pw_set    = pw_set_q;
endmodule

// File: tb/tb_combo_entry_ctrl.sv
// tb_combo_entry_ctrl: directed vectors checked every cycle against a digit-list model
module tb_combo_entry_ctrl;
    localparam int D = 4, W = 4, MF = 3, LC = 16;
    logic clk = 0, reset_n = 1, setPW = 0, attPW = 0;
    logic digit_valid = 0, enter_pulse = 0, clear_pulse = 0;
    logic [W-1:0] digit_in = 0;
    logic match, key_inhibit, pw_set;
    logic [D*W-1:0] entry_buf;
    logic [2:0] entry_cnt;
    logic [1:0] fail_cnt;
    int n_cmp = 0, n_bad = 0;

    combo_entry_ctrl #(.DIGITS(D), .DIGIT_W(W), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)) dut (
        .clk(clk), .reset_n(reset_n), .setPW(setPW), .attPW(attPW),
        .digit_valid(digit_valid), .digit_in(digit_in), .enter_pulse(enter_pulse),
        .clear_pulse(clear_pulse), .match(match), .key_inhibit(key_inhibit),
        .entry_buf(entry_buf), .entry_cnt(entry_cnt), .fail_cnt(fail_cnt), .pw_set(pw_set)
    );

    always #5 clk = ~clk;

    // model: mode 0 idle, 1 collecting, 2 locked out; entry held as a list of digits
    int m_mode = 0, m_n = 0, m_pw = 0, m_fail = 0, m_lt = 0;
    int m_dig[D] = '{default: 0};
    bit m_pwset = 0, m_match = 0;

    function automatic int value_of(input int dig[D], input int n);
        int v = 0;
        for (int i = 0; i < n; i++) v = v * (1 << W) + dig[i];
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0; m_n <= 0; m_pw <= 0; m_fail <= 0; m_lt <= 0;
            m_pwset <= 0; m_match <= 0; m_dig <= '{default: 0};
        end else begin
            automatic int mode = m_mode, n = m_n, pw = m_pw, fail = m_fail, lt = m_lt;
            automatic int dig[D] = m_dig;
            automatic bit pwset = m_pwset, armed = setPW | attPW;
            automatic bit hit = m_mode == 1 && m_n == D && m_pwset && value_of(m_dig, m_n) == m_pw;
            if (m_mode == 0) begin
                if (armed) begin mode = 1; n = 0; end
            end else if (m_mode == 1) begin
                if (!armed) mode = 0;
                else if (enter_pulse) begin
                    if (setPW) begin pw = value_of(m_dig, m_n); pwset = 1; fail = 0; end
                    else if (m_match) fail = 0;
                    else begin
                        fail++;
                        if (fail == MF) begin mode = 2; lt = 0; end
                    end
                    n = 0;
                end else if (clear_pulse) n = 0;
                else if (digit_valid && n < D) begin dig[n] = int'(digit_in); n++; end
            end else begin
                if (lt == LC - 1) begin mode = 0; lt = 0; fail = 0; end
                else lt++;
            end
            m_match <= hit && mode == 1;
            m_mode <= mode; m_n <= n; m_pw <= pw; m_fail <= fail; m_lt <= lt;
            m_pwset <= pwset; m_dig <= dig;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("match", match, m_match);
        chk("key_inhibit", key_inhibit, m_mode == 2);
        chk("entry_buf", entry_buf, value_of(m_dig, m_n));
        chk("entry_cnt", entry_cnt, m_n);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("pw_set", pw_set, m_pwset);
    end

    task automatic key(input int d);
        digit_in = W'(d);
        digit_valid = 1;
        @(negedge clk);
        digit_valid = 0;
    endtask

    task automatic enter();
        enter_pulse = 1;
        @(negedge clk);
        enter_pulse = 0;
    endtask

    task automatic clr();
        clear_pulse = 1;
        @(negedge clk);
        clear_pulse = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 reset_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_match", match, 0);
        chk("rst_inhibit", key_inhibit, 0);
        chk("rst_pw_set", pw_set, 0);
        chk("rst_cnt", entry_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_buf", entry_buf, 0);
        reset_n = 1;
        // store password 1234
        setPW = 1;
        @(negedge clk);
        key(1); key(2); key(3); key(4);
        chk("set_buf", entry_buf, 16'h1234);
        chk("set_cnt_full", entry_cnt, 4);
        enter();
        chk("set_pw_set", pw_set, 1);
        chk("set_cnt_clr", entry_cnt, 0);
        chk("set_fail", fail_cnt, 0);
        setPW = 0;
        @(negedge clk);
        // correct attempt
        attPW = 1;
        @(negedge clk);
        key(1); key(2); key(3); key(4);
        chk("match_lag", match, 0);
        @(negedge clk);
        chk("match_hit", match, 1);
        enter();
        chk("good_fail", fail_cnt, 0);
        // short entry and overflow digit
        key(1); key(2); key(3);
        @(negedge clk);
        chk("short_match", match, 0);
        chk("short_cnt", entry_cnt, 3);
        key(4); key(5);
        chk("ovf_buf", entry_buf, 16'h1234);
        chk("ovf_cnt", entry_cnt, 4);
        clr();
        chk("clr_cnt", entry_cnt, 0);
        // three wrong attempts
        for (int i = 0; i < 3; i++) begin
            key(9); key(9); key(9); key(9);
            @(negedge clk);
            enter();
            if (i < 2) chk("wrong_fail", fail_cnt, i + 1);
        end
        chk("lock_inhibit", key_inhibit, 1);
        n = 0;
        while (key_inhibit === 1'b1 && n < 40) begin
            digit_valid = (n == 3);
            digit_in = 4'h1;
            enter_pulse = (n == 5);
            clear_pulse = (n == 7);
            @(negedge clk);
            n++;
        end
        digit_valid = 0; enter_pulse = 0; clear_pulse = 0;
        chk("lock_len", n, 16);
        chk("unlock_fail", fail_cnt, 0);
        chk("unlock_inhibit", key_inhibit, 0);
        chk("lock_cnt", entry_cnt, 0);
        // simultaneous events
        @(negedge clk);
        key(1); key(2);
        digit_valid = 1; digit_in = 4'h7; enter_pulse = 1;
        @(negedge clk);
        digit_valid = 0; enter_pulse = 0;
        chk("sim_cnt", entry_cnt, 0);
        chk("sim_buf", entry_buf, 0);
        chk("sim_fail", fail_cnt, 1);
        key(3); key(4);
        clr();
        chk("clr2_cnt", entry_cnt, 0);
        chk("clr2_fail", fail_cnt, 1);
        key(2);
        digit_valid = 1; digit_in = 4'h8; clear_pulse = 1;
        @(negedge clk);
        digit_valid = 0; clear_pulse = 0;
        chk("clr_dig_cnt", entry_cnt, 0);
        // two-digit password is zero-padded high
        attPW = 0;
        @(negedge clk);
        setPW = 1;
        @(negedge clk);
        key(5); key(6);
        enter();
        setPW = 0; attPW = 1;
        key(0); key(0); key(5); key(6);
        @(negedge clk);
        chk("pad_match", match, 1);
        chk("pad_fail", fail_cnt, 0);
        // reset in the middle of lockout
        clr();
        @(negedge clk);
        enter(); enter(); enter();
        chk("lock2_inhibit", key_inhibit, 1);
        repeat (4) @(negedge clk);
        #1 reset_n = 0;
        #1;
        chk("rst_lock_inhibit", key_inhibit, 0);
        chk("rst_lock_pw_set", pw_set, 0);
        chk("rst_lock_match", match, 0);
        chk("rst_lock_fail", fail_cnt, 0);
        @(negedge clk);
        reset_n = 1; attPW = 0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
